// File: rtl/mult_div_unit.sv
// Multi-cycle signed multiply/divide unit (HI/LO result registers).
// Multiply: 32-step shift-add on operand magnitudes with a final negate.
// Divide:   32-step restoring division on magnitudes, quotient truncated
//           toward zero, remainder takes the dividend's sign.
// Define MD_DIV_EN to build the divider; without it a divide request
// completes immediately with hi/lo untouched.
module mult_div_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_i,
  input  logic        op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        div_zero_o
);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StMult = 2'd1,
`ifdef MD_DIV_EN
    StDiv  = 2'd2,
`endif
    StDone = 2'd3
  } state_e;

  state_e      state_q;
  logic [4:0]  cnt_q;
  logic [31:0] opnd_q;    // multiplicand or divisor magnitude
  logic [63:0] acc_q;     // {partial product | remainder, multiplier | quotient}
  logic        neg_q;     // result (product / quotient) must be negated
  logic        busy_q;
  logic        done_q;
  logic        div_zero_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;

  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [32:0] mul_sum;
  logic [63:0] mul_d;
  logic [63:0] mul_res;

`ifdef MD_DIV_EN
  logic        neg_r_q;   // remainder must be negated (negative dividend)
  logic [32:0] div_shift;
  logic [32:0] div_diff;
  logic [63:0] div_d;
  logic [31:0] quot;
  logic [31:0] rem;
`endif

  // Operand magnitudes and one iteration step of each datapath.
  always_comb begin
    mag_a   = a_i[31] ? (~a_i + 32'd1) : a_i;
    mag_b   = b_i[31] ? (~b_i + 32'd1) : b_i;
    // Add multiplicand into the upper half when the current multiplier bit is set, then shift.
    mul_sum = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
    mul_d   = {mul_sum, acc_q[31:1]};
    mul_res = neg_q ? (~mul_d + 64'd1) : mul_d;
`ifdef MD_DIV_EN
    // Shift next dividend bit into the remainder and try subtracting the divisor.
    div_shift = {acc_q[63:32], acc_q[31]};
    div_diff  = div_shift - {1'b0, opnd_q};
    div_d     = div_diff[32] ? {div_shift[31:0], acc_q[30:0], 1'b0}
                             : {div_diff[31:0],  acc_q[30:0], 1'b1};
    quot      = neg_q   ? (~div_d[31:0]  + 32'd1) : div_d[31:0];
    rem       = neg_r_q ? (~div_d[63:32] + 32'd1) : div_d[63:32];
`endif
  end

  // Control FSM, iteration datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      cnt_q      <= 5'd0;
      opnd_q     <= 32'd0;
      acc_q      <= 64'd0;
      neg_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
      hi_q       <= 32'd0;
      lo_q       <= 32'd0;
`ifdef MD_DIV_EN
      neg_r_q    <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          done_q     <= 1'b0;
          div_zero_q <= 1'b0;
          if (start_i) begin
            if (!op_i) begin
              state_q <= StMult;
              opnd_q  <= mag_a;
              acc_q   <= {32'd0, mag_b};
              neg_q   <= a_i[31] ^ b_i[31];
              cnt_q   <= 5'd0;
              busy_q  <= 1'b1;
            end else begin
`ifdef MD_DIV_EN
              if (b_i == 32'd0) begin
                // Zero divisor: report immediately, results keep their old value.
                state_q    <= StDone;
                done_q     <= 1'b1;
                div_zero_q <= 1'b1;
              end else begin
                state_q <= StDiv;
                opnd_q  <= mag_b;
                acc_q   <= {32'd0, mag_a};
                neg_q   <= a_i[31] ^ b_i[31];
                neg_r_q <= a_i[31];
                cnt_q   <= 5'd0;
                busy_q  <= 1'b1;
              end
`else
              state_q <= StDone;
              done_q  <= 1'b1;
`endif
            end
          end
        end
        StMult: begin
          acc_q <= mul_d;
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            state_q      <= StDone;
            busy_q       <= 1'b0;
            done_q       <= 1'b1;
            {hi_q, lo_q} <= mul_res;
          end
        end
`ifdef MD_DIV_EN
        StDiv: begin
          acc_q <= div_d;
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            state_q <= StDone;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            hi_q    <= rem;
            lo_q    <= quot;
          end
        end
`endif
        StDone: begin
          state_q    <= StIdle;
          done_q     <= 1'b0;
          div_zero_q <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign div_zero_o = div_zero_q;
  assign hi_o       = hi_q;
  assign lo_o       = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed table, random ops against
// an arithmetic reference model, and hand-written re-pulse / reset-abort runs.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        div_zero;

  mult_div_unit dut (
    .clk        (clk),
    .reset      (reset),
    .start_i    (start),
    .op_i       (op),
    .a_i        (a),
    .b_i        (b),
    .busy_o     (busy),
    .done_o     (done),
    .hi_o       (hi),
    .lo_o       (lo),
    .div_zero_o (div_zero)
  );

  always #5 clk = ~clk;

  int          n_chk  = 0;
  int          n_fail = 0;
  logic [31:0] hi_m   = 32'd0;  // model of retained HI
  logic [31:0] lo_m   = 32'd0;  // model of retained LO

  typedef struct {
    string       nm;
    logic        op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          lat;
  } vec_t;

  vec_t tv[7];

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // Reference: plain 64-bit signed arithmetic on the operands.
  task automatic model(input logic o, input logic [31:0] x, input logic [31:0] y,
                       output logic [31:0] eh, output logic [31:0] el,
                       output logic edz, output int lat);
    longint sx;
    longint sy;
    longint p;
    sx  = $signed(x);
    sy  = $signed(y);
    eh  = hi_m;
    el  = lo_m;
    edz = 1'b0;
    lat = 0;
    if (!o) begin
      p   = sx * sy;
      eh  = p[63:32];
      el  = p[31:0];
      lat = 32;
    end
`ifdef MD_DIV_EN
    else if (y == 32'd0) begin
      edz = 1'b1;
    end else begin
      p   = sx / sy;
      el  = p[31:0];
      p   = sx % sy;
      eh  = p[31:0];
      lat = 32;
    end
`endif
    hi_m = eh;
    lo_m = el;
  endtask

  // Issue one op, wait (bounded) for done, check timing and results.
  task automatic run_op(input string nm, input logic o, input logic [31:0] x,
                        input logic [31:0] y, input logic [31:0] eh,
                        input logic [31:0] el, input logic edz, input int lat);
    int got_j;
    int nb;
    @(negedge clk);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    @(posedge clk);
    #1;
    start = 1'b0;
    got_j = -1;
    nb    = 0;
    for (int j = 0; j <= 40; j++) begin
      if (done) begin
        got_j = j;
        break;
      end
      if (busy) nb++;
      @(posedge clk);
      #1;
    end
    chk({nm, " done latency"}, 64'(got_j), 64'(lat));
    chk({nm, " busy cycles"}, 64'(nb), 64'(lat));
    chk({nm, " hi"}, {32'd0, hi}, {32'd0, eh});
    chk({nm, " lo"}, {32'd0, lo}, {32'd0, el});
    chk({nm, " div_zero"}, {63'd0, div_zero}, {63'd0, edz});
    chk({nm, " busy at done"}, {63'd0, busy}, 64'd0);
    @(posedge clk);
    #1;
    chk({nm, " done one cycle"}, {63'd0, done}, 64'd0);
    chk({nm, " div_zero clears"}, {63'd0, div_zero}, 64'd0);
  endtask

  initial begin
    logic [31:0] eh;
    logic [31:0] el;
    logic        edz;
    int          lat;
    logic        o;
    logic [31:0] x;
    logic [31:0] y;
    int          ndone;
    int          dj;

    reset = 1'b1;
    start = 1'b0;
    op    = 1'b0;
    a     = 32'd0;
    b     = 32'd0;

    tv[0] = '{"mul 7x6",      1'b0, 32'd7,        32'd6,        32'h0,        32'h2A,       1'b0, 32};
    tv[1] = '{"mul -3x5",     1'b0, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0, 32};
    tv[2] = '{"mul max^2",    1'b0, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001, 1'b0, 32};
`ifdef MD_DIV_EN
    tv[3] = '{"div -7/2",     1'b1, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 32};
    tv[4] = '{"div min/-1",   1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h0,        32'h80000000, 1'b0, 32};
    tv[5] = '{"mul 7x6 again",1'b0, 32'd7,        32'd6,        32'h0,        32'h2A,       1'b0, 32};
    tv[6] = '{"div 5/0",      1'b1, 32'd5,        32'd0,        32'h0,        32'h2A,       1'b1, 0};
`else
    tv[3] = '{"div off -7/2", 1'b1, 32'hFFFFFFF9, 32'd2,        32'h3FFFFFFF, 32'h00000001, 1'b0, 0};
    tv[4] = '{"div off min",  1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h3FFFFFFF, 32'h00000001, 1'b0, 0};
    tv[5] = '{"mul 7x6 again",1'b0, 32'd7,        32'd6,        32'h0,        32'h2A,       1'b0, 32};
    tv[6] = '{"div off 5/0",  1'b1, 32'd5,        32'd0,        32'h0,        32'h2A,       1'b0, 0};
`endif

    repeat (3) @(posedge clk);
    #1;
    chk("reset busy", {63'd0, busy}, 64'd0);
    chk("reset done", {63'd0, done}, 64'd0);
    chk("reset div_zero", {63'd0, div_zero}, 64'd0);
    chk("reset hi", {32'd0, hi}, 64'd0);
    chk("reset lo", {32'd0, lo}, 64'd0);
    @(negedge clk);
    reset = 1'b0;

    // Directed table
    for (int i = 0; i < 7; i++) begin
      run_op(tv[i].nm, tv[i].op, tv[i].a, tv[i].b, tv[i].hi, tv[i].lo, tv[i].dz, tv[i].lat);
      hi_m = tv[i].hi;
      lo_m = tv[i].lo;
    end

    // Start re-pulsed during MULT and in DONE: must be ignored
    @(negedge clk);
    start = 1'b1; op = 1'b0; a = 32'd7; b = 32'd6;
    @(posedge clk);
    #1;
    start = 1'b0;
    ndone = 0;
    dj    = -1;
    for (int j = 0; j <= 40; j++) begin
      if (done) begin
        ndone++;
        dj = j;
      end
      if (j == 4 || j == 32) begin
        start = 1'b1; a = 32'd1; b = 32'd1;
      end
      if (j == 5 || j == 33) start = 1'b0;
      @(posedge clk);
      #1;
    end
    chk("repulse done count", 64'(ndone), 64'd1);
    chk("repulse done cycle", 64'(dj), 64'd32);
    chk("repulse hi", {32'd0, hi}, 64'd0);
    chk("repulse lo", {32'd0, lo}, 64'h2A);
    chk("repulse idle after", {63'd0, busy}, 64'd0);
    hi_m = 32'd0;
    lo_m = 32'h2A;

    // Reset mid-MULT (with a simultaneous start), then a fresh op
    @(negedge clk);
    start = 1'b1; op = 1'b0; a = 32'd7; b = 32'd6;
    @(posedge clk);
    #1;
    start = 1'b0;
    ndone = 0;
    dj    = -1;
    for (int j = 0; j <= 50; j++) begin
      if (done) begin
        ndone++;
        dj = j;
      end
      if (j == 9) begin
        reset = 1'b1; start = 1'b1; a = 32'd1; b = 32'd1;
      end
      if (j == 10) begin
        chk("abort busy", {63'd0, busy}, 64'd0);
        chk("abort hi", {32'd0, hi}, 64'd0);
        chk("abort lo", {32'd0, lo}, 64'd0);
        reset = 1'b0; start = 1'b0;
      end
      if (j == 11) begin
        start = 1'b1; a = 32'd3; b = 32'd4;
      end
      if (j == 12) start = 1'b0;
      if (j == 32) chk("abort no done k+33", {63'd0, done}, 64'd0);
      @(posedge clk);
      #1;
    end
    chk("abort done count", 64'(ndone), 64'd1);
    chk("abort restart done cycle", 64'(dj), 64'd44);
    chk("abort restart hi", {32'd0, hi}, 64'd0);
    chk("abort restart lo", {32'd0, lo}, 64'd12);
    hi_m = 32'd0;
    lo_m = 32'd12;

    // Random operations against the model
    for (int i = 0; i < 24; i++) begin
      o = 1'($urandom_range(0, 1));
      x = $urandom;
      y = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) y = y >> $urandom_range(16, 31);
      if ($urandom_range(0, 7) == 0) x = 32'h80000000;
      model(o, x, y, eh, el, edz, lat);
      run_op($sformatf("rand%0d op%0d", i, o), o, x, y, eh, el, edz, lat);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
